// File: rtl/vector_pkg.sv
// Shared constants, element/address types and sequencer states for the vector ROM blocks.
package vector_pkg;
   localparam int DEFAULT_RAM_WIDTH            = 4;
   localparam int DEFAULT_RAM_ADDR_BITS_VECTOR = 6;

   typedef logic [DEFAULT_RAM_WIDTH-1:0]            elem_t;
   typedef logic [DEFAULT_RAM_ADDR_BITS_VECTOR-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/vector_stream_reader_if.sv
// Element stream from the vector reader to the CNN datapath: valid/ready with index and last tags.
interface vector_stream_reader_if
   import vector_pkg::*;
#(
   parameter int RAM_WIDTH            = DEFAULT_RAM_WIDTH,
   parameter int RAM_ADDR_BITS_VECTOR = DEFAULT_RAM_ADDR_BITS_VECTOR
) ();
   logic                            m_valid;
   logic                            m_ready;
   logic [RAM_WIDTH-1:0]            m_data;
   logic [RAM_ADDR_BITS_VECTOR-1:0] m_index;
   logic                            m_last;

   modport master (output m_valid, m_data, m_index, m_last, input m_ready);
   modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/vsr_out_stage.sv
// Output register of the reader: captures the ROM word when empty or being emptied, one cycle to m_valid.
// Element, index and last hold while downstream stalls; the drain transfer empties the stage.
module vsr_out_stage #(
   parameter int RAM_WIDTH            = 4,
   parameter int RAM_ADDR_BITS_VECTOR = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            run,
   input  logic                            drain,
   input  logic [RAM_WIDTH-1:0]            din,
   input  logic [RAM_ADDR_BITS_VECTOR-1:0] idx,
   input  logic                            is_last,
   input  logic                            ready,
   output logic                            load,
   output logic                            xfer,
   output logic                            valid,
   output logic [RAM_WIDTH-1:0]            data,
   output logic [RAM_ADDR_BITS_VECTOR-1:0] index,
   output logic                            last
);
   assign xfer = valid && ready;
   assign load = run && (!valid || ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         index <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
         index <= idx;
         last  <= is_last;
      end else if (drain && xfer) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end
   end
endmodule

// File: rtl/vector_stream_reader.sv
// Sweeps the vector ROM from START_ADDR to END_ADDR on start, streams the words out, pulses done at the end.
// Defining VECTOR_STREAM_READER_CHECKSUM_EN adds a running sum of the transferred elements.
module vector_stream_reader
   import vector_pkg::*;
#(
   parameter int RAM_WIDTH            = DEFAULT_RAM_WIDTH,
   parameter int RAM_ADDR_BITS_VECTOR = DEFAULT_RAM_ADDR_BITS_VECTOR,
   parameter int START_ADDR           = 0,
   parameter int END_ADDR             = 63
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic [RAM_ADDR_BITS_VECTOR-1:0] addr_vector,
   input  logic [RAM_WIDTH-1:0]            dataIn,
   vector_stream_reader_if.master          strm
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
   ,
   output logic [RAM_WIDTH+RAM_ADDR_BITS_VECTOR-1:0] checksum
`endif
);
   localparam logic [RAM_ADDR_BITS_VECTOR-1:0] FIRST = RAM_ADDR_BITS_VECTOR'(START_ADDR);
   localparam logic [RAM_ADDR_BITS_VECTOR-1:0] FINAL = RAM_ADDR_BITS_VECTOR'(END_ADDR);

   if (START_ADDR < 0 || START_ADDR > END_ADDR || END_ADDR >= (1 << RAM_ADDR_BITS_VECTOR)) begin : g_bad_window
      $error("vector_stream_reader: address window does not fit the ROM");
   end

   state_t                          state, state_nxt;
   logic [RAM_ADDR_BITS_VECTOR-1:0] ptr, ptr_nxt;
   logic                            done_nxt;
   logic                            load, xfer;
   logic                            run_st, drain_st, at_end;

   assign run_st      = (state == RUN);
   assign drain_st    = (state == DRAIN);
   assign at_end      = (ptr == FINAL);
   assign busy        = (state != IDLE);
   assign addr_vector = ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= FIRST;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         done  <= done_nxt;
      end
   end

   // The pointer stops on END_ADDR rather than wrapping; DRAIN waits for that last element to leave.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               ptr_nxt   = FIRST;
            end
         end
         RUN: begin
            if (load) begin
               if (at_end) state_nxt = DRAIN;
               else        ptr_nxt   = ptr + RAM_ADDR_BITS_VECTOR'(1);
            end
         end
         DRAIN: begin
            if (xfer) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   vsr_out_stage #(
      .RAM_WIDTH           (RAM_WIDTH),
      .RAM_ADDR_BITS_VECTOR(RAM_ADDR_BITS_VECTOR)
   ) u_out (
      .clk    (clk),
      .rst    (rst),
      .run    (run_st),
      .drain  (drain_st),
      .din    (dataIn),
      .idx    (ptr),
      .is_last(at_end),
      .ready  (strm.m_ready),
      .load   (load),
      .xfer   (xfer),
      .valid  (strm.m_valid),
      .data   (strm.m_data),
      .index  (strm.m_index),
      .last   (strm.m_last)
   );

`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
   localparam int CW = RAM_WIDTH + RAM_ADDR_BITS_VECTOR;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          checksum <= '0;
      else if (state == IDLE && start)  checksum <= '0;
      else if (xfer)                    checksum <= checksum + CW'(strm.m_data);
   end
`endif
endmodule

// File: tb/tb_vector_stream_reader.sv
// Scoreboard bench for vector_stream_reader: full-window and single-element instances against a queue model.
module tb_vector_stream_reader;
   import vector_pkg::*;

   localparam int START = 0;
   localparam int LAST  = 63;
   localparam int W     = LAST - START + 1;
   localparam int ONE   = 5;

   typedef struct {
      elem_t d;
      addr_t i;
      logic  l;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   logic  start, busy, done;
   addr_t addr;
   elem_t rom;
   logic  one_start, one_busy, one_done;
   addr_t one_addr;
   elem_t one_rom;

   int    checks = 0, errors = 0, cyc = 0, rmode = 0;
   int    sweeps_done = 0, sweep_cnt = 0, last_xfer = 0, exp_first = -1, exp_done = -1;
   int    one_sweeps = 0, one_last_xfer = 0;
   bit    model_busy = 1'b0, prev_stall = 1'b0, one_mbusy = 1'b0;
   elem_t held_d;
   addr_t held_i;
   exp_t  q[$];
   exp_t  oq[$];

`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
   localparam int CW = DEFAULT_RAM_WIDTH + DEFAULT_RAM_ADDR_BITS_VECTOR;
   logic [CW-1:0] csum, one_csum, exp_sum;
`endif

   vector_stream_reader_if #(.RAM_WIDTH(DEFAULT_RAM_WIDTH), .RAM_ADDR_BITS_VECTOR(DEFAULT_RAM_ADDR_BITS_VECTOR)) s_if ();
   vector_stream_reader_if #(.RAM_WIDTH(DEFAULT_RAM_WIDTH), .RAM_ADDR_BITS_VECTOR(DEFAULT_RAM_ADDR_BITS_VECTOR)) o_if ();

   vector_stream_reader #(.START_ADDR(START), .END_ADDR(LAST)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .addr_vector(addr), .dataIn(rom), .strm(s_if)
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
      , .checksum(csum)
`endif
   );

   vector_stream_reader #(.START_ADDR(ONE), .END_ADDR(ONE)) u_one (
      .clk(clk), .rst(rst), .start(one_start), .busy(one_busy), .done(one_done),
      .addr_vector(one_addr), .dataIn(one_rom), .strm(o_if)
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
      , .checksum(one_csum)
`endif
   );

   // ROM contents: word i holds i mod 16.
   assign rom     = elem_t'(addr % 16);
   assign one_rom = elem_t'(one_addr % 16);

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       s_if.m_ready = 1'b1;
         1:       s_if.m_ready = ~s_if.m_ready;
         2:       s_if.m_ready = 1'($urandom_range(0, 1));
         default: s_if.m_ready = 1'b0;
      endcase
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Main instance: model of accepted sweeps, transfers, stalls and done.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         model_busy = 1'b0;
         sweep_cnt  = 0;
         prev_stall = 1'b0;
         exp_first  = -1;
         exp_done   = -1;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(s_if.m_valid), 64'(1));
            chk("stall_data", 64'(s_if.m_data), 64'(held_d));
            chk("stall_index", 64'(s_if.m_index), 64'(held_i));
         end
         prev_stall = s_if.m_valid && !s_if.m_ready;
         held_d     = s_if.m_data;
         held_i     = s_if.m_index;
         if (s_if.m_valid && s_if.m_ready) begin
            if (q.size() == 0) chk("xfer_with_empty_queue", 64'(q.size()), 64'(1));
            else begin
               e = q.pop_front();
               chk("xfer_data", 64'(s_if.m_data), 64'(e.d));
               chk("xfer_index", 64'(s_if.m_index), 64'(e.i));
               chk("xfer_last", 64'(s_if.m_last), 64'(e.l));
               if (sweep_cnt == 0 && exp_first >= 0) chk("first_valid_cycle", 64'(cyc), 64'(exp_first));
               sweep_cnt++;
               last_xfer = cyc;
            end
         end
         if (done) begin
            chk("done_transfer_count", 64'(sweep_cnt), 64'(W));
            chk("done_after_last_xfer", 64'(cyc - last_xfer), 64'(1));
            chk("done_queue_empty", 64'(q.size()), 64'(0));
            chk("done_valid_low", 64'(s_if.m_valid), 64'(0));
            if (exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
            chk("checksum", 64'(csum), 64'(exp_sum));
`endif
            sweeps_done++;
            sweep_cnt  = 0;
            model_busy = 1'b0;
            exp_first  = -1;
            exp_done   = -1;
         end
         chk("busy", 64'(busy), 64'(model_busy));
         if (!model_busy && start) begin
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
            exp_sum = '0;
`endif
            for (int a = START; a <= LAST; a++) begin
               q.push_back('{d: elem_t'(a % 16), i: addr_t'(a), l: (a == LAST)});
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
               exp_sum = exp_sum + CW'(a % 16);
`endif
            end
            model_busy = 1'b1;
            if (rmode == 0) begin
               exp_first = cyc + 2;
               exp_done  = cyc + W + 2;
            end
         end
      end
   end

   // Single-element instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         oq.delete();
         one_mbusy = 1'b0;
      end else begin
         if (o_if.m_valid && o_if.m_ready) begin
            if (oq.size() == 0) chk("one_xfer_with_empty_queue", 64'(oq.size()), 64'(1));
            else begin
               e = oq.pop_front();
               chk("one_data", 64'(o_if.m_data), 64'(e.d));
               chk("one_index", 64'(o_if.m_index), 64'(e.i));
               chk("one_last", 64'(o_if.m_last), 64'(e.l));
            end
            one_last_xfer = cyc;
         end
         if (one_done) begin
            chk("one_done_after_xfer", 64'(cyc - one_last_xfer), 64'(1));
            chk("one_queue_empty", 64'(oq.size()), 64'(0));
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
            chk("one_checksum", 64'(one_csum), 64'(ONE % 16));
`endif
            one_sweeps++;
            one_mbusy = 1'b0;
         end
         chk("one_busy", 64'(one_busy), 64'(one_mbusy));
         if (!one_mbusy && one_start) begin
            oq.push_back('{d: elem_t'(ONE % 16), i: addr_t'(ONE), l: 1'b1});
            one_mbusy = 1'b1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_sweeps(input bit one, input int target, input int bound);
      int n = 0;
      while (((one ? one_sweeps : sweeps_done) < target) && n < bound) begin
         step(1);
         n++;
      end
      chk(one ? "one_sweep_timeout" : "sweep_timeout", 64'(one ? one_sweeps : sweeps_done), 64'(target));
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_m_valid"}, 64'(s_if.m_valid), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_addr"}, 64'(addr), 64'(START));
      chk({tag, "_m_data"}, 64'(s_if.m_data), 64'(0));
      chk({tag, "_m_index"}, 64'(s_if.m_index), 64'(0));
      chk({tag, "_m_last"}, 64'(s_if.m_last), 64'(0));
`ifdef VECTOR_STREAM_READER_CHECKSUM_EN
      chk({tag, "_checksum"}, 64'(csum), 64'(0));
`endif
   endtask

   initial begin
      int base;
      rst       = 1'b0;
      start     = 1'b0;
      one_start = 1'b0;
      o_if.m_ready = 1'b0;
      #1 rst = 1'b1;
      step(3);
      check_cleared("reset");
      chk("reset_one_valid", 64'(o_if.m_valid), 64'(0));
      rst = 1'b0;
      step(2);

      // Full sweep, downstream always ready.
      pulse_start();
      wait_sweeps(0, 1, 200);

      // Toggling ready, then random ready.
      rmode = 1;
      pulse_start();
      wait_sweeps(0, 2, 400);
      rmode = 2;
      pulse_start();
      wait_sweeps(0, 3, 400);
      rmode = 0;
      step(2);

      // start re-pulsed mid-sweep must not disturb the sweep.
      pulse_start();
      step(9);
      pulse_start();
      wait_sweeps(0, 4, 200);

      // Reset with element 18 stalled.
      base = sweeps_done;
      pulse_start();
      step(18);
      #1 rmode = 3;
      @(posedge clk);
      #3;
      chk("pre_rst_valid", 64'(s_if.m_valid), 64'(1));
      chk("pre_rst_index", 64'(s_if.m_index), 64'(18));
      rst = 1'b1;
      #1;
      check_cleared("async_rst");
      step(2);
      rst   = 1'b0;
      rmode = 0;
      step(3);
      chk("no_done_after_rst", 64'(sweeps_done), 64'(base));
      pulse_start();
      wait_sweeps(0, base + 1, 200);

      // start held high: back-to-back sweeps.
      base  = sweeps_done;
      start = 1'b1;
      wait_sweeps(0, base + 1, 200);
      step(10);
      start = 1'b0;
      wait_sweeps(0, base + 2, 200);

      // Random ready with random start noise while busy.
      base  = sweeps_done;
      rmode = 2;
      pulse_start();
      for (int k = 0; k < 20; k++) begin
         start = 1'($urandom_range(0, 1));
         step(1);
      end
      start = 1'b0;
      wait_sweeps(0, base + 1, 400);
      rmode = 0;

      // Single-element window, ready high then stalled.
      o_if.m_ready = 1'b1;
      one_start = 1'b1;
      step(1);
      one_start = 1'b0;
      wait_sweeps(1, 1, 20);
      o_if.m_ready = 1'b0;
      one_start = 1'b1;
      step(1);
      one_start = 1'b0;
      step(4);
      chk("one_stalled_valid", 64'(o_if.m_valid), 64'(1));
      chk("one_stalled_last", 64'(o_if.m_last), 64'(1));
      o_if.m_ready = 1'b1;
      wait_sweeps(1, 2, 20);

      step(3);
      chk("final_queue_empty", 64'(q.size()), 64'(0));
      chk("final_busy", 64'(busy), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vector_stream_reader.md
Name: vector_stream_reader

Overview:
Read-side sequencer for the single-column vector ROM.
- Drives the ROM's asynchronous address input and samples its combinational data.
- Sweeps a contiguous address window on a start pulse and emits the elements as a valid/ready stream to the CNN datapath (e.g. dense-layer MAC).
- Reports completion with a one-cycle done pulse.

Parameters:
- RAM_WIDTH, 4, element width in bits; must match the ROM data width.
- RAM_ADDR_BITS_VECTOR, 6, ROM address width.
- START_ADDR, 0, first address read.
- END_ADDR, 63, last address read. Requires START_ADDR <= END_ADDR < 2**RAM_ADDR_BITS_VECTOR; otherwise elaboration fails.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last element is accepted downstream.
- addr_vector  out  RAM_ADDR_BITS_VECTOR  address to the ROM; driven straight from the pointer register.
- dataIn  in  RAM_WIDTH  ROM asynchronous read data for addr_vector.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts; a transfer occurs when m_valid && m_ready.
- m_data  out  RAM_WIDTH  registered element.
- m_index  out  RAM_ADDR_BITS_VECTOR  address the element came from.
- m_last  out  1  high with the element from END_ADDR.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ptr=START_ADDR; addr_vector=START_ADDR; m_valid=0; m_data=0; m_index=0; m_last=0; busy=0; done=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> RUN, ptr=START_ADDR.
  - start=0 -> stay. done deasserts here.
- RAM load rule (RUN only): "load" = (m_valid==0) || m_ready.
  - On load: m_data<=dataIn, m_index<=ptr, m_last<=(ptr==END_ADDR), m_valid<=1.
  - If ptr==END_ADDR -> DRAIN with ptr held; else ptr<=ptr+1.
- Without load: m_data, m_index, m_last and ptr hold, so data stays stable under backpressure.
- DRAIN: on m_valid && m_ready -> m_valid<=0, m_last<=0, done<=1 for one cycle, state<=IDLE.
- Latency and throughput:
  - start sampled at edge N -> first m_valid at edge N+2.
  - With m_ready held high: one element per cycle.
  - Full window of W=END_ADDR-START_ADDR+1 elements: done pulses at edge N+W+2.
- Single-element window (START_ADDR==END_ADDR): the first load goes straight to DRAIN with m_last=1.
- start while busy is ignored; it neither restarts nor queues.
- start in the same cycle as done (already back in IDLE) begins a new sweep normally.
- ptr never wraps; the END_ADDR compare stops it. The +1 is computed at RAM_ADDR_BITS_VECTOR width.
- m_ready while m_valid=0 has no effect.
- Reset mid-sweep abandons the sweep: no done pulse, and m_valid drops immediately (asynchronous).

Optional Feature:
- Macro: VECTOR_STREAM_READER_CHECKSUM_EN.
- When defined, adds output port checksum, width RAM_WIDTH+RAM_ADDR_BITS_VECTOR.
  - Unsigned running sum of every m_data transferred (m_valid && m_ready).
  - Cleared on reset and on the accepted start.
  - Final value is stable from the done cycle until the next start.
- When undefined: no port and no adder; behaviour is otherwise identical.

Decomposition:
- Shared package vector_pkg holds:
  - RAM_WIDTH and RAM_ADDR_BITS_VECTOR default constants.
  - Element and address typedefs.
  - The IDLE/RUN/DRAIN state enum, reused by the future writer-side block.
- One natural sub-module: vsr_out_stage.
  - Contains the output register, the load rule, m_last and m_index.
  - The top keeps the FSM, the pointer and the checksum.

Test Plan:
- ROM model b_ram[i]=i mod 16, defaults, m_ready=1, start pulse at cycle 0 -> m_data 0,1,..,15,0,.. on cycles 2..65; m_last only with m_index=63; done at cycle 66; checksum=480 when the feature is enabled.
- Same sweep, m_ready toggling 1,0,1,0 -> no element dropped or duplicated; m_data/m_index stable on every ready=0 cycle; 64 transfers total.
- START_ADDR=END_ADDR=5 -> exactly one transfer, m_data=5, m_index=5, m_last=1, done one cycle after the transfer.
- start reasserted at cycle 10 mid-sweep -> ignored; sequence and done timing identical to the first scenario.
- rst asserted at cycle 20 (element 18 pending with m_ready=0) -> m_valid=0 and busy=0 without waiting for a clock edge; no done; a later start restarts at address 0.
- start held high continuously -> back-to-back sweeps, each delivering 64 elements with done between them; no element from the next sweep appears before done.
